// File: rtl/eth_frame_tx_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : eth_frame_tx_stage                                         |
// | Description : Latches a frame header, buffers payload bytes in a FWFT    |
// |               FIFO, and sequences header then payload onto eth_axis_tx.  |
// |               Optional minimum-payload padding with ETH_TX_MIN_PAD_EN.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module eth_frame_tx_stage #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        s_eth_hdr_valid,
  input  logic        s_eth_hdr_ready,
  output logic [47:0] s_eth_dest_mac,
  output logic [47:0] s_eth_src_mac,
  output logic [15:0] s_eth_type,
  output logic [7:0]  s_eth_payload_axis_tdata,
  output logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tlast,
  output logic        s_eth_payload_axis_tuser,
  input  logic        s_eth_payload_axis_tready,
  input  logic        busy,
  output logic        frame_done,
  output logic [15:0] byte_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  logic [8:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [15:0] r_byte_count;
  logic [47:0] r_dest;
  logic [47:0] r_src;
  logic [15:0] r_type;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [8:0] w_head;
  logic       w_in_payload;
  logic       w_tvalid;
  logic       w_tlast;
  logic [7:0] w_tdata;
  logic       w_beat;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = in_valid && in_ready;

  // Reset gating keeps every handshake output quiet while rst is held.
  assign w_in_payload = (r_state == S_PAYLOAD) && !rst;
  assign w_beat       = w_tvalid && s_eth_payload_axis_tready;

`ifdef ETH_TX_MIN_PAD_EN
  logic r_pad;
  logic w_short;

  // True while this beat would still leave the frame below 46 bytes.
  assign w_short  = ({1'b0, r_byte_count} + 17'd1) < 17'd46;
  assign w_tvalid = w_in_payload && (r_pad || !w_empty);
  assign w_tdata  = (w_in_payload && !r_pad && !w_empty) ? w_head[7:0] : 8'h00;
  assign w_tlast  = w_in_payload && !w_short && (r_pad || (!w_empty && w_head[8]));
  assign w_pop    = w_beat && !r_pad;

  // Pad mode starts when a short frame's last byte leaves and ends on the closing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad <= 1'b0;
    end else if (w_beat && !r_pad && w_head[8] && w_short) begin
      r_pad <= 1'b1;
    end else if (w_beat && w_tlast) begin
      r_pad <= 1'b0;
    end
  end
`else
  assign w_tvalid = w_in_payload && !w_empty;
  assign w_tdata  = w_tvalid ? w_head[7:0] : 8'h00;
  assign w_tlast  = w_tvalid && w_head[8];
  assign w_pop    = w_beat;
`endif

  // FIFO storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  // FIFO pointers; reset flushes any buffered payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Frame sequencer: header latch, header handshake, payload beats, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_count <= 16'd0;
      r_dest       <= 48'd0;
      r_src        <= 48'd0;
      r_type       <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_dest       <= dest_mac;
            r_src        <= src_mac;
            r_type       <= eth_type;
            r_byte_count <= 16'd0;
            r_state      <= S_HDR;
          end
        end
        S_HDR: begin
          if (!busy && s_eth_hdr_ready) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_beat) begin
            if (r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'd1;
            if (w_tlast) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready               = (r_state == S_IDLE) && !rst;
  assign in_ready                  = !w_full && !rst;
  assign s_eth_hdr_valid           = (r_state == S_HDR) && !busy && !rst;
  assign s_eth_dest_mac            = rst ? 48'd0 : r_dest;
  assign s_eth_src_mac             = rst ? 48'd0 : r_src;
  assign s_eth_type                = rst ? 16'd0 : r_type;
  assign s_eth_payload_axis_tdata  = w_tdata;
  assign s_eth_payload_axis_tvalid = w_tvalid;
  assign s_eth_payload_axis_tlast  = w_tlast;
  assign s_eth_payload_axis_tuser  = 1'b0;
  assign frame_done                = (r_state == S_DONE) && !rst;
  assign byte_count                = rst ? 16'd0 : r_byte_count;

endmodule
`default_nettype wire

// File: doc/eth_frame_tx_stage.md
# eth_frame_tx_stage

Frame-level transmit stage that feeds the eth_axis_tx header and payload ports that the byte-writer functions drive. It latches a frame header, buffers incoming payload bytes with their last flags in a small first-word-fall-through (FWFT) FIFO, and sequences header handshake then payload beats onto the eth_axis_tx slave interface. It signals completion once per frame.

## Interface
- DEPTH, 16, payload FIFO depth in bytes; power of two, minimum 4
- AW, 4, FIFO address width; must equal log2(DEPTH)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- start_valid  in  1  frame header request
- start_ready  out  1  high only in IDLE
- dest_mac  in  48  latched on start handshake
- src_mac  in  48  latched on start handshake
- eth_type  in  16  latched on start handshake
- in_data  in  8  payload byte
- in_last  in  1  marks final payload byte of frame
- in_valid  in  1  byte valid
- in_ready  out  1  = !fifo_full
- s_eth_hdr_valid  out  1  header valid to eth_axis_tx
- s_eth_hdr_ready  in  1  header accept from eth_axis_tx
- s_eth_dest_mac / s_eth_src_mac / s_eth_type  out  48/48/16  latched header fields
- s_eth_payload_axis_tdata  out  8  payload byte
- s_eth_payload_axis_tvalid  out  1  payload valid
- s_eth_payload_axis_tlast  out  1  final beat
- s_eth_payload_axis_tuser  out  1  constant 0
- s_eth_payload_axis_tready  in  1  payload accept
- busy  in  1  eth_axis_tx busy; header is not offered while high
- frame_done  out  1  one-cycle pulse after final beat accepted
- byte_count  out  16  beats sent in current/last frame, saturating at 16'hFFFF

## Operation
- FIFO: DEPTH entries of {last, data}. Write when in_valid && in_ready. Read on accepted payload beat. Pointers are AW+1 bits; full/empty use the MSB compare. Head entry is combinationally visible (FWFT).
- Push while full is never accepted; in_ready is low. Push and pop in the same cycle when not full both occur and the count is unchanged.
- The FIFO accepts bytes in any state, including before the header, so payload may pre-fill.
- FSM states:
  - IDLE: start_ready=1. On start_valid, latch the header fields, clear byte_count, go to HDR.
  - HDR: s_eth_hdr_valid = !busy. When s_eth_hdr_valid && s_eth_hdr_ready, go to PAYLOAD.
  - PAYLOAD: tvalid = !fifo_empty (or pad pending); tdata = head data; tlast = head last. Each accepted beat increments byte_count. An accepted beat with tlast=1 goes to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
- tvalid, once asserted, holds with stable tdata/tlast until tready. Stability is guaranteed because the FIFO head only changes on pop.
- Header outputs hold their latched values from the start handshake until the next start handshake.

## Timing
- Reset values:
  - Outputs: start_ready=0 during rst, then 1; in_ready=0 during rst; all s_eth_* outputs 0; frame_done=0; byte_count=0.
  - Internal: FIFO empty, state IDLE.
- rst mid-frame aborts immediately: the FIFO is flushed, no tlast is emitted, and frame_done is not pulsed.
- Start accepted in cycle N → s_eth_hdr_valid in N+1 (if !busy).
- Header accepted in cycle M → first tvalid in M+1 if the FIFO is non-empty.
- Sustained throughput of one beat per cycle with tready=1 and a non-empty FIFO.
- A byte written in cycle K is presentable as tdata in K+1 at the earliest. There is no same-cycle write-through.
- Final beat accepted in cycle L → frame_done in L+1 → start_ready in L+2.

## Configuration
- ETH_TX_MIN_PAD_EN defined:
  - If the frame's last FIFO byte is accepted with byte_count+1 < 46, tlast is suppressed on that beat.
  - Zero bytes are then emitted (tdata=0, tvalid=1, no FIFO pop) until the 46th beat, which carries tlast=1.
  - Frames of 46 or more bytes are unchanged.
- ETH_TX_MIN_PAD_EN undefined: no padding logic is present. tlast always comes from the FIFO entry, and frames of any length pass unchanged.

## Test plan
- Basic frame: pre-fill bytes 0x11,0x22,0x33 (last on 0x33), start with dest=0x0A0B0C0D0E0F, type=0x0800, hdr_ready=1, tready=1 → header one cycle, then beats 11,22,33 with tlast on 33; frame_done one cycle later; byte_count=3 (pad undefined).
- Backpressure: toggle tready every cycle across 8 bytes → tdata/tlast are stable while stalled, no byte is lost or duplicated, byte_count=8.
- FIFO full: push 17 bytes with DEPTH=16 and tready=0 → in_ready drops after the 16th byte; the 17th is accepted only after the first pop.
- Busy/header stall: busy=1 for 5 cycles in HDR → s_eth_hdr_valid stays 0, then asserts; no payload beat precedes the header handshake.
- Reset mid-frame: rst after 2 of 5 beats → all outputs are 0 next cycle, the FIFO is empty, no frame_done; a following 1-byte frame sends correctly.
- Padding (ETH_TX_MIN_PAD_EN): 10-byte frame → 46 beats total; beats 11–46 are 0x00; tlast only on beat 46; byte_count=46.
